// File: rtl/bridge_scheduler_pkg.sv
// bridge_utils: shared enums and constants for the AXI2APB bridge scheduler.
// Holds the path command/status encodings, burst response codes and the
// scheduler state encoding. No ports.
package bridge_utils;
    typedef enum logic [1:0] {
        CMD_IDLE          = 2'b00,
        CMD_GET_ADDR_DATA = 2'b01,
        CMD_GET_RESP      = 2'b10
    } cmd_t;
    typedef enum logic [1:0] {
        INFO_IDLE   = 2'b00,
        INFO_BUSY   = 2'b01,
        INFO_SWITCH = 2'b10
    } info_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_COLLECT,
        ST_WR_APB,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_APB,
        ST_RD_RESP
    } state_t;
endpackage

// File: rtl/bridge_scheduler_rr_arbiter.sv
// bridge_rr_arbiter: 2-way round-robin arbiter with registered last grant.
// Ports: clk, rst_n (sync active-low), i_req[0]=write / i_req[1]=read,
// i_accept (winner taken this cycle), o_grant one-hot, o_valid any request.
module bridge_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant,
    output logic       o_valid
);
    logic r_last_rd;
    always_comb begin
        o_grant = (&i_req) ? (r_last_rd ? 2'b01 : 2'b10) : i_req;
        o_valid = |i_req;
    end
    // Reset to "read had it last" so write wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_last_rd <= 1'b1;
        else if (i_accept && o_valid)
            r_last_rd <= o_grant[1];
    end
endmodule

// File: rtl/bridge_scheduler.sv
// bridge_scheduler: sequencer sharing one APB master between AXI write and read paths.
// Ports: clk, rst_n (sync active-low); write path i_wr_awvalid/o_wr_cmd/i_wr_info/i_wr_len;
// read path i_rd_arvalid/o_rd_cmd/i_rd_info/i_rd_len; o_grant one-hot owner;
// APB o_apb_req/o_apb_write/i_apb_ready/i_apb_slverr; o_beat_done, o_resp, o_busy.
// Optional feature: define BRIDGE_WATCHDOG_EN to force-complete a beat (as SLVERR)
// after TIMEOUT_CYCLES cycles of waiting on apb_ready.
module bridge_scheduler
    import bridge_utils::*;
#(
    parameter int LEN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr_awvalid,
    output logic [1:0]           o_wr_cmd,
    input  logic [1:0]           i_wr_info,
    input  logic [LEN_WIDTH-1:0] i_wr_len,
    input  logic                 i_rd_arvalid,
    output logic [1:0]           o_rd_cmd,
    input  logic [1:0]           i_rd_info,
    input  logic [LEN_WIDTH-1:0] i_rd_len,
    output logic [1:0]           o_grant,
    output logic                 o_apb_req,
    output logic                 o_apb_write,
    input  logic                 i_apb_ready,
    input  logic                 i_apb_slverr,
    output logic                 o_beat_done,
    output logic [1:0]           o_resp,
    output logic                 o_busy
);
    localparam int CW = LEN_WIDTH + 1;
    if (LEN_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("bridge_scheduler: LEN_WIDTH and TIMEOUT_CYCLES must be >= 1");
    end
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [1:0]    w_grant;
    logic          w_valid, w_done, w_err, w_last, w_wr;
    bridge_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    ({i_rd_arvalid, i_wr_awvalid}),
        .i_accept (r_state == ST_IDLE),
        .o_grant  (w_grant),
        .o_valid  (w_valid)
    );
`ifdef BRIDGE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd;
    logic            w_timeout;
    assign w_timeout = o_apb_req && !i_apb_ready && r_wd == WD_W'(TIMEOUT_CYCLES - 1);
    assign w_done    = o_apb_req && (i_apb_ready || w_timeout);
    assign w_err     = (i_apb_ready && i_apb_slverr) || w_timeout;
    always_ff @(posedge clk) begin
        if (!rst_n || w_done || !o_apb_req)
            r_wd <= '0;
        else
            r_wd <= r_wd + WD_W'(1);
    end
`else
    assign w_done = o_apb_req && i_apb_ready;
    assign w_err  = i_apb_slverr;
`endif
    assign w_last = r_cnt == CW'(1);
    assign w_wr   = r_state == ST_WR_APB;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            o_wr_cmd    <= CMD_IDLE;
            o_rd_cmd    <= CMD_IDLE;
            o_grant     <= 2'b00;
            o_apb_req   <= 1'b0;
            o_apb_write <= 1'b0;
            o_beat_done <= 1'b0;
            o_resp      <= RESP_OKAY;
            o_busy      <= 1'b0;
        end else begin
            o_beat_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_valid) begin
                    o_grant  <= w_grant;
                    o_busy   <= 1'b1;
                    o_wr_cmd <= w_grant[0] ? CMD_GET_ADDR_DATA : CMD_IDLE;
                    o_rd_cmd <= w_grant[1] ? CMD_GET_ADDR_DATA : CMD_IDLE;
                    r_state  <= w_grant[0] ? ST_WR_COLLECT : ST_RD_ADDR;
                end
                ST_WR_COLLECT: if (i_wr_info == INFO_SWITCH) begin
                    r_cnt       <= CW'(i_wr_len) + CW'(1);
                    o_wr_cmd    <= CMD_IDLE;
                    o_apb_req   <= 1'b1;
                    o_apb_write <= 1'b1;
                    r_state     <= ST_WR_APB;
                end
                ST_RD_ADDR: if (i_rd_info == INFO_SWITCH) begin
                    r_cnt       <= CW'(i_rd_len) + CW'(1);
                    o_rd_cmd    <= CMD_IDLE;
                    o_apb_req   <= 1'b1;
                    o_apb_write <= 1'b0;
                    r_state     <= ST_RD_APB;
                end
                ST_WR_APB, ST_RD_APB: begin
                    // Dropping apb_req after each beat gives the APB master a SETUP phase.
                    if (w_done) begin
                        o_beat_done <= 1'b1;
                        o_apb_req   <= 1'b0;
                        r_cnt       <= r_cnt - CW'(1);
                        r_err       <= r_err | w_err;
                        // Reads report the beat's own error; writes report the sticky error.
                        o_resp      <= (w_err || (w_wr && r_err)) ? RESP_SLVERR : RESP_OKAY;
                        if (w_last) begin
                            o_wr_cmd <= w_wr ? CMD_GET_RESP : CMD_IDLE;
                            o_rd_cmd <= w_wr ? CMD_IDLE : CMD_GET_RESP;
                            r_state  <= w_wr ? ST_WR_RESP : ST_RD_RESP;
                        end
                    end else begin
                        o_apb_req <= 1'b1;
                    end
                end
                ST_WR_RESP, ST_RD_RESP: if ((r_state == ST_WR_RESP ? i_wr_info : i_rd_info) == INFO_IDLE) begin
                    r_state     <= ST_IDLE;
                    r_err       <= 1'b0;
                    o_wr_cmd    <= CMD_IDLE;
                    o_rd_cmd    <= CMD_IDLE;
                    o_grant     <= 2'b00;
                    o_apb_write <= 1'b0;
                    o_resp      <= RESP_OKAY;
                    o_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_err       <= 1'b0;
                    o_wr_cmd    <= CMD_IDLE;
                    o_rd_cmd    <= CMD_IDLE;
                    o_grant     <= 2'b00;
                    o_apb_req   <= 1'b0;
                    o_apb_write <= 1'b0;
                    o_resp      <= RESP_OKAY;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bridge_scheduler.sv
// tb_bridge_scheduler: scoreboard bench for bridge_scheduler with path and APB responders.
module tb_bridge_scheduler;
    import bridge_utils::*;
    localparam int LW = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic wr_awvalid, rd_arvalid;
    logic [1:0] wr_info = INFO_IDLE, rd_info = INFO_IDLE;
    logic [LW-1:0] wr_len = '0, rd_len = '0;
    logic apb_ready = 1'b0, apb_slverr = 1'b0;
    logic [1:0] wr_cmd, rd_cmd, grant, resp;
    logic apb_req, apb_write, beat_done, busy;
    int wr_pend = 0, rd_pend = 0, waits = 0, wcnt = 0, beat_idx = 0;
    logic [15:0] err_mask = '0;
    logic stray = 1'b0, hang = 1'b0;
    int checks = 0, failures = 0;
    typedef struct {int kind; logic [1:0] v0; logic [1:0] v1;} exp_t;
    exp_t exp_q[$];
    logic [1:0] prev_grant = 2'b00, prev_wcmd = 2'b00;

    assign wr_awvalid = wr_pend > 0;
    assign rd_arvalid = rd_pend > 0;

    bridge_scheduler #(.LEN_WIDTH(LW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wr_awvalid(wr_awvalid), .o_wr_cmd(wr_cmd), .i_wr_info(wr_info), .i_wr_len(wr_len),
        .i_rd_arvalid(rd_arvalid), .o_rd_cmd(rd_cmd), .i_rd_info(rd_info), .i_rd_len(rd_len),
        .o_grant(grant), .o_apb_req(apb_req), .o_apb_write(apb_write),
        .i_apb_ready(apb_ready), .i_apb_slverr(apb_slverr),
        .o_beat_done(beat_done), .o_resp(resp), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        e.kind = k; e.v0 = a; e.v1 = b;
        exp_q.push_back(e);
    endtask

    task automatic push_beats(input logic wr, input int n, input logic [15:0] emask);
        for (int i = 0; i < n; i++) push(1, {1'b0, wr}, emask[i] ? RESP_SLVERR : RESP_OKAY);
    endtask

    task automatic take(input int kind, input string name, output exp_t e, output bit ok);
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: event seen but nothing expected", name);
        end else begin
            e = exp_q.pop_front();
            ok = e.kind == kind;
            if (!ok) begin
                checks++; failures++;
                $display("FAIL %s: event kind %0d seen, expected kind %0d", name, kind, e.kind);
            end
        end
    endtask

    // Monitor: compares each DUT event against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit ok;
        if (rst_n) begin
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                take(0, "grant", e, ok);
                if (ok) chk("grant", grant, e.v0);
                chk("busy_with_grant", busy, 1);
            end
            if (beat_done) begin
                take(1, "beat", e, ok);
                if (ok) begin
                    chk("beat_apb_write", apb_write, e.v0);
                    if (!e.v0[0]) chk("read_beat_resp", resp, e.v1);
                end
            end
            if (wr_cmd == CMD_GET_RESP && prev_wcmd != CMD_GET_RESP) begin
                take(2, "write_resp", e, ok);
                if (ok) chk("write_resp", resp, e.v0);
            end
        end
        prev_grant = grant;
        prev_wcmd = wr_cmd;
    end

    // Path and APB slave responders, driven on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            wr_info = INFO_IDLE; rd_info = INFO_IDLE;
            apb_ready = 1'b0; apb_slverr = 1'b0; wcnt = 0; beat_idx = 0;
        end else begin
            if (wr_cmd == CMD_GET_ADDR_DATA) begin
                if (wr_info == INFO_IDLE) begin wr_info = INFO_BUSY; wr_pend--; beat_idx = 0; end
                else wr_info = INFO_SWITCH;
            end else if (wr_cmd == CMD_GET_RESP)
                wr_info = (wr_info == INFO_SWITCH) ? INFO_BUSY : INFO_IDLE;
            if (rd_cmd == CMD_GET_ADDR_DATA) begin
                if (rd_info == INFO_IDLE) begin rd_info = INFO_BUSY; rd_pend--; beat_idx = 0; end
                else rd_info = INFO_SWITCH;
            end else if (rd_cmd == CMD_GET_RESP)
                rd_info = (rd_info == INFO_SWITCH) ? INFO_BUSY : INFO_IDLE;
            apb_slverr = 1'b0;
            if (apb_req && !hang) begin
                if (wcnt >= waits) begin
                    apb_ready = 1'b1; apb_slverr = err_mask[beat_idx]; beat_idx++; wcnt = 0;
                end else begin
                    apb_ready = 1'b0; wcnt++;
                end
            end else begin
                apb_ready = stray && !apb_req;
                apb_slverr = stray && !apb_req;
                wcnt = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        wr_pend = 0; rd_pend = 0; hang = 1'b0; stray = 1'b0; err_mask = '0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cyc();
            done = exp_q.size() == 0 && !busy && wr_pend <= 0 && rd_pend <= 0;
        end
        chk({name, "_completed"}, done, 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        do_reset();
        chk("reset_wr_cmd", wr_cmd, CMD_IDLE);
        chk("reset_rd_cmd", rd_cmd, CMD_IDLE);
        chk("reset_grant", grant, 0);
        chk("reset_apb", {apb_req, apb_write, beat_done}, 0);
        chk("reset_resp", resp, RESP_OKAY);
        chk("reset_busy", busy, 0);

        // Single write, len=3, two wait states per beat.
        push(0, 2'b01, 0); push_beats(1, 4, 0); push(2, RESP_OKAY, 0);
        waits = 2; wr_len = 3; wr_pend = 1;
        wait_idle("write4", 300);

        // Both paths requesting after reset: write, read, write.
        do_reset();
        push(0, 2'b01, 0); push_beats(1, 1, 0); push(2, RESP_OKAY, 0);
        push(0, 2'b10, 0); push_beats(0, 1, 0);
        push(0, 2'b01, 0); push_beats(1, 1, 0); push(2, RESP_OKAY, 0);
        waits = 1; wr_len = 0; rd_len = 0; wr_pend = 2; rd_pend = 1;
        wait_idle("round_robin", 300);

        // 16-beat read with stray apb_ready between beats, then a 1-beat read.
        push(0, 2'b10, 0); push_beats(0, 16, 0);
        waits = 0; stray = 1'b1; rd_len = 15; rd_pend = 1;
        wait_idle("read16", 400);
        stray = 1'b0;
        push(0, 2'b10, 0); push_beats(0, 1, 0);
        rd_len = 0; rd_pend = 1;
        wait_idle("read1", 100);

        // Write with an error on beat 2, read with an error on beat 1, clean write.
        push(0, 2'b01, 0); push_beats(1, 3, 0); push(2, RESP_SLVERR, 0);
        err_mask = 16'h0002; wr_len = 2; wr_pend = 1;
        wait_idle("write_err", 200);
        push(0, 2'b10, 0); push_beats(0, 2, 16'h0001);
        err_mask = 16'h0001; rd_len = 1; rd_pend = 1;
        wait_idle("read_err", 200);
        push(0, 2'b01, 0); push_beats(1, 2, 0); push(2, RESP_OKAY, 0);
        err_mask = 16'h0000; wr_len = 1; wr_pend = 1;
        wait_idle("write_clean", 200);

        // Reset during the second beat of a write, then a normal write.
        push(0, 2'b01, 0); push_beats(1, 4, 0); push(2, RESP_OKAY, 0);
        waits = 2; wr_len = 3; wr_pend = 1;
        for (int i = 0; i < 100 && !beat_done; i++) cyc();
        for (int i = 0; i < 100 && !apb_req; i++) cyc();
        chk("mid_reset_in_beat2", apb_req, 1);
        rst_n = 1'b0;
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
        chk("mid_reset_outputs", {wr_cmd, rd_cmd, grant, apb_req, apb_write, beat_done, resp, busy}, 0);
        push(0, 2'b01, 0); push_beats(1, 1, 0); push(2, RESP_OKAY, 0);
        waits = 0; wr_len = 0; wr_pend = 1;
        wait_idle("after_reset", 200);

        // APB slave that never answers.
`ifdef BRIDGE_WATCHDOG_EN
        push(0, 2'b01, 0); push_beats(1, 1, 16'h0001); push(2, RESP_SLVERR, 0);
        hang = 1'b1; wr_len = 0; wr_pend = 1;
        for (int i = 0; i < 50 && !apb_req; i++) cyc();
        n = 0;
        while (n < 50 && !beat_done) begin cyc(); n++; end
        chk("watchdog_cycles", n, 8);
        wait_idle("watchdog", 100);
        hang = 1'b0;
`else
        push(0, 2'b01, 0);
        hang = 1'b1; wr_len = 0; wr_pend = 1;
        n = 0;
        repeat (30) begin cyc(); n += int'(beat_done); end
        chk("hang_req_held", apb_req, 1);
        chk("hang_no_beat", n, 0);
        chk("hang_queue", exp_q.size(), 0);
        do_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
